// File: rtl/ringbuffer_drain.sv
// Drains ring-buffer entries to a UART as uppercase hex text, one line per entry.
// Each entry is read from a synchronous RAM, then sent MSB nibble first and terminated by 0x0A.
module ringbuffer_drain #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  ram_rd,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  read_done,
  output logic [7:0]            uart_data,
  output logic                  uart_valid,
  input  logic                  uart_ready
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    NEWLINE
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'd0, nib};
    else             return 8'h37 + {4'd0, nib};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs depend on state only, so uart_valid never follows uart_ready combinationally.
  always_comb begin
    state_nxt  = state;
    ram_rd     = 1'b0;
    read_done  = 1'b0;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = FETCH;
      end
      FETCH: begin
        ram_rd    = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: begin
        read_done = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        uart_valid = 1'b1;
        uart_data  = hex_ascii(shreg[DATA_WIDTH-1 -: 4]);
        if (uart_ready && cnt == CNT_W'(1)) state_nxt = NEWLINE;
      end
      NEWLINE: begin
        uart_valid = 1'b1;
        uart_data  = 8'h0A;
        if (uart_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and nibble counter advance only on an accepted character.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == LATCH) begin
      shreg <= ram_data;
      cnt   <= CNT_W'(NIBBLES);
    end else if (state == SEND && uart_ready) begin
      shreg <= {shreg[DATA_WIDTH-5:0], 4'h0};
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Directed bench for ringbuffer_drain: a small ring-buffer/RAM model feeds entries,
// a negedge monitor collects UART transfers, and expected bytes are written out by hand.
module tb_ringbuffer_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty;
  logic        ram_rd;
  logic [31:0] ram_data;
  logic        read_done;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready;

  int total = 0;
  int bad   = 0;

  ringbuffer_drain #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .ram_rd     (ram_rd),
    .ram_data   (ram_data),
    .read_done  (read_done),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready)
  );

  always #5 clk = ~clk;

  // Ring buffer model: entries written by the stimulus, consumed on read_done.
  logic [31:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pcyc   = 0;
  int          push_cyc = 0;
  logic        rdy_mode = 1'b0;

  always_comb empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    pcyc = pcyc + 1;
  end

  always @(posedge clk) begin
    if (ram_rd)    ram_data <= mem[rd_ptr[3:0]];
    if (read_done) rd_ptr   <= rd_ptr + 1;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode) uart_ready = ~uart_ready;
  end

  // Monitor
  logic [7:0] rx [$];
  int         tx_cyc [$];
  int         rr_cyc [$];
  int         rdn_cyc [$];
  int         rd_cnt = 0;
  int         rr_cnt = 0;
  int         fv_cyc = -1;
  int         stall_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (uart_valid && uart_ready) begin
      rx.push_back(uart_data);
      tx_cyc.push_back(pcyc);
    end
    if (uart_valid && fv_cyc < 0) fv_cyc = pcyc;
    if (read_done) begin
      rd_cnt = rd_cnt + 1;
      rdn_cyc.push_back(pcyc);
    end
    if (ram_rd) begin
      rr_cnt = rr_cnt + 1;
      rr_cyc.push_back(pcyc);
    end
    if (prev_stall && (!uart_valid || uart_data != prev_data)) stall_viol = stall_viol + 1;
    prev_stall = uart_valid && !uart_ready;
    prev_data  = uart_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rx.delete();
    tx_cyc.delete();
    rr_cyc.delete();
    rdn_cyc.delete();
    rd_cnt     = 0;
    rr_cnt     = 0;
    fv_cyc     = -1;
    stall_viol = 0;
    prev_stall = 1'b0;
  endtask

  task automatic push(input logic [31:0] val);
    mem[wr_ptr[3:0]] = val;
    wr_ptr   = wr_ptr + 1;
    push_cyc = pcyc;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (rx.size() < n) chk("timeout_rx", rx.size(), n);
  endtask

  // exp holds nine bytes, first character in the top byte.
  task automatic chk_line(input string tag, input int base, input logic [71:0] exp);
    for (int i = 0; i < 9; i++) begin
      if (base + i < rx.size()) chk($sformatf("%s_b%0d", tag, i), rx[base+i], exp[71-8*i -: 8]);
      else                      chk($sformatf("%s_b%0d_missing", tag, i), 32'hFFFF_FFFF, exp[71-8*i -: 8]);
    end
  endtask

  initial begin
    int held;
    int k;
    reset      = 1'b1;
    uart_ready = 1'b1;
    ram_data   = '0;

    // Reset state with an empty buffer
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", uart_valid, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_read_done", read_done, 0);
    reset = 1'b0;
    clr();
    repeat (20) @(posedge clk);
    #1;
    chk("idle_ram_rd_count", rr_cnt, 0);
    chk("idle_valid", uart_valid, 0);
    chk("idle_data", uart_data, 0);

    // Single entry, ready held high
    clr();
    push(32'h1234ABCD);
    wait_rx(9, 60);
    chk_line("e1", 0, 72'h31_32_33_34_41_42_43_44_0A);
    chk("e1_consecutive", tx_cyc[8] - tx_cyc[0], 8);
    chk("e1_ram_rd_lat", rr_cyc[0] - push_cyc, 1);
    chk("e1_read_done_lat", rdn_cyc[0] - push_cyc, 2);
    chk("e1_valid_lat", fv_cyc - push_cyc, 3);
    repeat (5) @(posedge clk);
    #1;
    chk("e1_read_done_cnt", rd_cnt, 1);
    chk("e1_rx_cnt", rx.size(), 9);

    // Same entry, ready alternating
    clr();
    rdy_mode = 1'b1;
    push(32'h1234ABCD);
    wait_rx(9, 200);
    chk_line("alt", 0, 72'h31_32_33_34_41_42_43_44_0A);
    rdy_mode = 1'b0;
    @(posedge clk);
    #2;
    uart_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("alt_stall_stable", stall_viol, 0);
    chk("alt_read_done_cnt", rd_cnt, 1);
    chk("alt_rx_cnt", rx.size(), 9);

    // Two entries back to back
    clr();
    push(32'hDEADBEEF);
    push(32'h00000000);
    wait_rx(18, 100);
    chk_line("b2b_a", 0, 72'h44_45_41_44_42_45_45_46_0A);
    chk_line("b2b_b", 9, 72'h30_30_30_30_30_30_30_30_0A);
    chk("b2b_second_fetch", rr_cyc[1] - tx_cyc[8], 2);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_read_done_cnt", rd_cnt, 2);
    chk("b2b_ram_rd_cnt", rr_cnt, 2);

    // Reset mid-line after the third transfer
    clr();
    push(32'h1234ABCD);
    wait_rx(3, 60);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", uart_valid, 0);
    chk("mid_rst_data", uart_data, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_newline", rx.size(), 3);
    push(32'hCAFE0123);
    wait_rx(12, 60);
    chk_line("after_rst", 3, 72'h43_41_46_45_30_31_32_33_0A);

    // Reset during LATCH: pulse suppressed, entry stays unread and is resent
    clr();
    push(32'h00000FA5);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("latch_rst_read_done", read_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_rx(9, 60);
    chk_line("latch_rst", 0, 72'h30_30_30_30_30_46_41_35_0A);
    repeat (5) @(posedge clk);
    #1;
    chk("latch_rst_read_done_cnt", rd_cnt, 1);

    // Long stall on the first character
    clr();
    uart_ready = 1'b0;
    push(32'hFFFFFFFF);
    k = 0;
    while (!uart_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("stall_valid_seen", uart_valid, 1);
    held = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_valid && uart_data == 8'h46) held++;
    end
    chk("stall_hold_cycles", held, 50);
    chk("stall_no_transfer", rx.size(), 0);
    @(posedge clk);
    #1;
    uart_ready = 1'b1;
    wait_rx(9, 40);
    chk_line("stall", 0, 72'h46_46_46_46_46_46_46_46_0A);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_rx_cnt", rx.size(), 9);
    chk("stall_stable", stall_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
